// File: rtl/if_prefetch_unit_pkg.sv
// Shared fetch-stage constants: exception codes, reset PC and fetch FSM state encodings.
package if_prefetch_unit_pkg;

   localparam int EXC_CODE_WIDTH = 5;

   // Code 0 is the MIPS interrupt cause, so "no exception" needs its own reserved value.
   localparam logic [EXC_CODE_WIDTH-1:0] EC_NONE = 5'h1F;
   localparam logic [EXC_CODE_WIDTH-1:0] EC_INT  = 5'h00;
   localparam logic [EXC_CODE_WIDTH-1:0] EC_TLBL = 5'h02;
   localparam logic [EXC_CODE_WIDTH-1:0] EC_ADEL = 5'h04;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_REQ     = 2'd1;
   localparam logic [1:0] ST_DISCARD = 2'd2;
   localparam logic [1:0] ST_HALT    = 2'd3;

endpackage

// File: rtl/if_prefetch_unit_if.sv
// Fetch-stage bundle: redirect input, instruction-memory req/ack channel and the valid/ready link to ID.
interface if_prefetch_unit_if
   import if_prefetch_unit_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int EXC_W  = EXC_CODE_WIDTH
);
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [DATA_W-1:0] imem_rdata;
   logic [EXC_W-1:0]  mmu_exc_code;
   logic              has_int_from_cp0;
   logic              id_valid;
   logic              id_ready;
   logic [ADDR_W-1:0] id_pc;
   logic [DATA_W-1:0] id_inst;
   logic [EXC_W-1:0]  id_exc_code;

   modport master (
      input  redirect_valid, redirect_pc, imem_ack, imem_rdata, mmu_exc_code,
             has_int_from_cp0, id_ready,
      output imem_req, imem_addr, id_valid, id_pc, id_inst, id_exc_code
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_ack, imem_rdata, mmu_exc_code,
             has_int_from_cp0, id_ready,
      input  imem_req, imem_addr, id_valid, id_pc, id_inst, id_exc_code
   );

endinterface

// File: rtl/if_prefetch_unit_fifo.sv
// Synchronous DEPTH x W queue with flush; head is a combinational read. Push when full / pop when empty are ignored.
module if_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  logic [W-1:0]               push_dat,
   input  logic                       pop,
   output logic [W-1:0]               head_dat,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [W-1:0]   mem_q [DEPTH];
   logic [PTR_W:0] wr_q, wr_d;
   logic [PTR_W:0] rd_q, rd_d;

   assign count    = wr_q - rd_q;
   assign full     = (count == (PTR_W+1)'(DEPTH));
   assign empty    = (wr_q == rd_q);
   assign head_dat = mem_q[rd_q[PTR_W-1:0]];

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (flush) begin
         wr_d = '0;
         rd_d = '0;
      end else begin
         if (push && !full) wr_d = wr_q + 1'b1;
         if (pop && !empty) rd_d = rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full && !flush) mem_q[wr_q[PTR_W-1:0]] <= push_dat;
   end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding imem req/ack master, prefetch queue toward ID.
// Redirect flushes the queue; misaligned PC and MMU faults become queued exception entries that halt fetch.
module if_prefetch_unit
   import if_prefetch_unit_pkg::*;
#(
   parameter int                 ADDR_W   = 32,
   parameter int                 DATA_W   = 32,
   parameter int                 DEPTH    = 4,
   parameter int                 EXC_W    = EXC_CODE_WIDTH,
   parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
)(
   input logic                clk,
   input logic                rst_n,
   if_prefetch_unit_if.master bus
);
   localparam int ENT_W = ADDR_W + DATA_W + EXC_W;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [EXC_W-1:0] XC_NONE = EXC_W'(EC_NONE);
   localparam logic [EXC_W-1:0] XC_INT  = EXC_W'(EC_INT);
   localparam logic [EXC_W-1:0] XC_ADEL = EXC_W'(EC_ADEL);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              req_q, req_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ENT_W-1:0]  last_q, last_d;

   logic              fifo_push, fifo_pop, fifo_full, fifo_empty, slot_after;
   logic [ENT_W-1:0]  push_dat, head_dat, head_view;
   logic [CNT_W-1:0]  fifo_cnt;
   logic [ADDR_W-1:0] pc_inc;
   logic [EXC_W-1:0]  head_exc;

   if_fifo #(.DEPTH(DEPTH), .W(ENT_W)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (bus.redirect_valid),
      .push     (fifo_push),
      .push_dat (push_dat),
      .pop      (fifo_pop),
      .head_dat (head_dat),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_cnt)
   );

   assign fifo_pop   = !fifo_empty && bus.id_ready;
   assign pc_inc     = pc_q + ADDR_W'(4);
   // Only one request is ever outstanding, so count < DEPTH while in REQ; a same-cycle pop always frees a slot.
   assign slot_after = fifo_pop || (fifo_cnt < CNT_W'(DEPTH - 1));

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      req_d     = req_q;
      addr_d    = addr_q;
      fifo_push = 1'b0;
      push_dat  = {pc_q, {DATA_W{1'b0}}, XC_ADEL};
      last_d    = fifo_pop ? head_dat : last_q;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_full) begin
               if (pc_q[1:0] != 2'b00) begin
                  fifo_push = 1'b1;
                  state_d   = ST_HALT;
               end else begin
                  req_d   = 1'b1;
                  addr_d  = pc_q;
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (bus.imem_ack) begin
               fifo_push = 1'b1;
               req_d     = 1'b0;
               if (bus.mmu_exc_code != XC_NONE) begin
                  push_dat = {addr_q, {DATA_W{1'b0}}, bus.mmu_exc_code};
                  state_d  = ST_HALT;
               end else begin
                  push_dat = {addr_q, bus.imem_rdata, XC_NONE};
                  pc_d     = pc_inc;
                  if (slot_after) begin
                     req_d  = 1'b1;
                     addr_d = pc_inc;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
         end
         ST_DISCARD: begin
            if (bus.imem_ack) begin
               req_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: ;
      endcase

      // A still-unacked request must finish in DISCARD so the memory never sees two outstanding.
      if (bus.redirect_valid) begin
         fifo_push = 1'b0;
         pc_d      = bus.redirect_pc;
         addr_d    = addr_q;
         if ((state_q == ST_REQ || state_q == ST_DISCARD) && !bus.imem_ack) begin
            req_d   = 1'b1;
            state_d = ST_DISCARD;
         end else begin
            req_d   = 1'b0;
            state_d = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         req_q   <= 1'b0;
         addr_q  <= RESET_PC;
         last_q  <= {{ADDR_W{1'b0}}, {DATA_W{1'b0}}, XC_NONE};
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         last_q  <= last_d;
      end
   end

   assign head_view = fifo_empty ? last_q : head_dat;
   assign head_exc  = head_view[EXC_W-1:0];

   assign bus.imem_req  = req_q;
   assign bus.imem_addr = addr_q;
   assign bus.id_valid  = !fifo_empty;
   assign bus.id_pc     = head_view[ENT_W-1 -: ADDR_W];

   // Interrupt tag is applied on the way out only, and never overrides a fault already in the entry.
   always_comb begin
      bus.id_exc_code = head_exc;
      bus.id_inst     = head_view[EXC_W +: DATA_W];
      if (!fifo_empty && head_exc == XC_NONE && bus.has_int_from_cp0) begin
         bus.id_exc_code = XC_INT;
         bus.id_inst     = '0;
      end
   end

endmodule
